// File: rtl/mac_sched_pkg.sv
// Shared types, sizing helpers and the round-robin pick for the MAC scheduler.
package mac_sched_pkg;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam int T_DEF     = 16;
  localparam int R_DEF     = 3;
  localparam int VEC_S_DEF = 5;
  localparam int R_MAX     = 8;

  function automatic int id_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic int cnt_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int ID_W  = id_width(R_DEF);
  localparam int CNT_W = cnt_width(VEC_S_DEF);

  // First eligible requester at or after ptr, wrapping modulo r (lowest offset wins).
  function automatic logic [2:0] rr_pick(input logic [R_MAX-1:0] elig,
                                         input logic [2:0] ptr, input int r);
    logic [2:0] pick;
    int idx;
    pick = ptr;
    for (int k = R_MAX - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % r;
      if (k < r && elig[idx[2:0]]) pick = idx[2:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/mac_sched_tag_fifo.sv
// Small FIFO of requester ids, one entry per vector handed to the MAC.
module mac_sched_tag_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Outstanding tags are bounded by the requester count, so a push never meets a full FIFO.
  assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: rtl/mac_sched.sv
// Round-robin arbiter sharing one MAC between R requesters, one whole vector per grant,
// with tagged routing of each MAC result back to its requester.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int T     = 16,
  parameter int R     = 3,
  parameter int VEC_S = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*T-1:0] req_a,
  input  logic [R*T-1:0] req_b,
  input  logic [R*T-1:0] req_x,
  output logic [T-1:0]   mac_a,
  output logic [T-1:0]   mac_b,
  output logic [T-1:0]   mac_x,
  output logic           mac_valid_in,
  input  logic [T-1:0]   mac_f,
  input  logic           mac_valid_out,
  output logic [R-1:0]   rsp_valid,
  input  logic [R-1:0]   rsp_ready,
  output logic [R*T-1:0] rsp_data,
  output logic           err
);
  localparam int IW = id_width(R);
  localparam int CW = cnt_width(VEC_S);

  state_t        state_reg;
  logic [IW-1:0] gnt_reg, rr_ptr_reg, pick, tag;
  logic [CW-1:0] count_reg;
  logic [R-1:0]  outstanding_reg, outstanding_next, eligible, rsp_fire, set_mask;
  logic          push, pop, xfer, fifo_empty, fifo_full;

  assign eligible = req_valid & ~outstanding_reg;
  assign pick     = IW'(rr_pick(R_MAX'(eligible), 3'(rr_ptr_reg), R));
  assign push     = (state_reg == IDLE) && (|eligible);
  assign set_mask = push ? (R'(1) << pick) : '0;
  assign xfer     = (state_reg == STREAM) && req_valid[gnt_reg] && req_ready[gnt_reg];
  assign pop      = mac_valid_out && !fifo_empty;
  assign rsp_fire = rsp_valid & rsp_ready;

  // A consumed response frees its requester only from the following cycle on.
  assign outstanding_next = (outstanding_reg & ~rsp_fire) | set_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      rr_ptr_reg   <= '0;
      count_reg    <= '0;
      req_ready    <= '0;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_x        <= '0;
      mac_valid_in <= 1'b0;
    end else begin
      mac_valid_in <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (push) begin
            gnt_reg   <= pick;
            count_reg <= '0;
            req_ready <= R'(1) << pick;
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            mac_a        <= req_a[gnt_reg*T +: T];
            mac_b        <= req_b[gnt_reg*T +: T];
            mac_x        <= req_x[gnt_reg*T +: T];
            mac_valid_in <= 1'b1;
            count_reg    <= count_reg + 1'b1;
            if (count_reg == CW'(VEC_S - 1)) begin
              rr_ptr_reg <= (gnt_reg == IW'(R - 1)) ? '0 : gnt_reg + 1'b1;
              req_ready  <= '0;
              state_reg  <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_reg <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      err             <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      for (int i = 0; i < R; i++) begin
        if (rsp_fire[i]) rsp_valid[i] <= 1'b0;
        if (pop && tag == IW'(i)) begin
          rsp_valid[i]         <= 1'b1;
          rsp_data[i*T +: T]   <= mac_f;
        end
      end
      if (mac_valid_out && fifo_empty) err <= 1'b1;
    end
  end

  mac_sched_tag_fifo #(.DEPTH(R), .W(IW)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pick),
    .pop       (pop),
    .pop_data  (tag),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assert property (@(posedge clk) disable iff (!reset) push |-> !fifo_full);

endmodule

// File: doc/mac_sched.md
# mac_sched

Round-robin scheduler that shares one `part3_mac` (NUM_S=1) instance among R layer requesters. Each requester streams one dot-product vector of VEC_S elements (a, b, x) at a time. The scheduler grants the MAC for a whole vector, tags the vector with the requester id, and routes the MAC result back to that requester's result register. It sits between several layer controllers and a single MAC in the multi-layer network datapath.

## Interface
Parameters:
- T, 16, data width of a, b, x and result
- R, 3, number of requesters (2..8)
- VEC_S, 5, elements per vector (matches the MAC's VEC_S)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  R  requester i presents an element
- req_ready  out  R  element accepted from requester i
- req_a  in  R*T  weight per requester, slice i = [i*T +: T], signed
- req_b  in  R*T  bias per requester, signed
- req_x  in  R*T  input per requester, unsigned (MAC convention)
- mac_a, mac_b, mac_x  out  T each  registered operands to the MAC
- mac_valid_in  out  1  registered element strobe to the MAC
- mac_f  in  T  MAC result, signed
- mac_valid_out  in  1  MAC result strobe
- rsp_valid  out  R  result pending for requester i
- rsp_ready  in  R  requester i consumes its result
- rsp_data  out  R*T  per-requester result register, slice i
- err  out  1  sticky: a MAC result arrived with no tag outstanding

## Operation
- Reset values: all outputs 0. Internal state: state=IDLE, rr_ptr=0, outstanding=0, tag FIFO empty, element count=0.
- Eligibility: requester i is eligible when req_valid[i] is high and outstanding[i] is low. This gives at most one vector in flight per requester and at most R tags in flight. Results can never be dropped.
- FSM with two states:
  - IDLE: req_ready=0. If any requester is eligible, pick the first eligible one at or after rr_ptr (wrapping modulo R) as gnt. Register gnt, set outstanding[gnt], push gnt to the tag FIFO, clear the element count, and go to STREAM. With no eligible requester, stay in IDLE.
  - STREAM: req_ready[gnt]=1, all other req_ready=0. On a transfer (req_valid[gnt] & req_ready[gnt]): register the gnt operand slices into mac_a/b/x, set mac_valid_in=1 for one cycle, and increment the count. On the transfer with count==VEC_S-1, set rr_ptr=(gnt+1) mod R and go to IDLE.
- Requester gaps: req_valid[gnt] may drop mid-vector. mac_valid_in is then 0 for those cycles, and the MAC accumulation tolerates the gaps. There is no timeout.
- Return path: on mac_valid_out, pop tag t, set rsp_data[t]=mac_f and rsp_valid[t]=1.
- Result consumption: on rsp_valid[i] & rsp_ready[i], clear rsp_valid[i] and outstanding[i]. rsp_data[i] holds its value.
- Simultaneous events:
  - A pop and a push in the same cycle are both performed.
  - A response handshake on i and an eligibility check on i in the same cycle: outstanding is cleared first for the next cycle, so i is not granted before that next cycle.
- mac_valid_out with the tag FIFO empty: set err=1, keep rsp state unchanged. err clears only on reset.
- Arithmetic: no width changes; mac_f passes through unmodified. ReLU and saturation belong to the requester.
- Reset asserted mid-vector: the MAC must be reset in the same domain. All in-flight vectors are discarded, and requesters restart their vectors.

## Timing
- Grant latency: eligible in IDLE at cycle c → STREAM with req_ready[gnt]=1 at c+1.
- Element latency: transfer at cycle k → mac_valid_in=1 with that element's operands at k+1.
- Vector spacing: last transfer at k → IDLE at k+1, next grant effective (STREAM) at k+2. That is one bubble cycle per vector, giving a throughput of VEC_S elements per VEC_S+1 cycles under continuous demand.
- Result latency: mac_valid_out at cycle m → rsp_valid[t]=1 at m+1.
- End-to-end with NUM_S=1 (the MAC's own latency is 3 cycles from its last valid_in): last transfer at k → rsp_valid at k+5.
- rsp_valid[i] stays high until it is consumed.

## Structure
- Package mac_sched_pkg:
  - state enum {IDLE, STREAM}
  - ID_W = $clog2(R) (minimum 1)
  - CNT_W = $clog2(VEC_S)
- Sub-module mac_sched_tag_fifo: depth R, width ID_W, push/pop/empty/full. Pushing while full is an internal assertion failure.
- The round-robin pick is a combinational function in the package.

## Test plan
- Single requester: R=3, only req 0 sends a=1..5, x=2, b=10 → mac_valid_in pulses 5 times; rsp_data[0]=40 (sum 30 + bias 10) with rsp_valid[0] at last transfer +5.
- All three requesters continuously valid → grant order 0,1,2,0. Each vector occupies exactly 5 STREAM cycles with 1 IDLE cycle between vectors, and results land in the matching rsp slots.
- Requester 1 never asserts rsp_ready → after its first result, req 1 is never granted again; reqs 0 and 2 keep alternating.
- Gap injection: req 2 drops req_valid for 3 cycles mid-vector → mac_valid_in has a matching 3-cycle hole; the result equals the gap-free value.
- Spurious mac_valid_out with no vector outstanding → err=1 next cycle and stays 1; rsp_valid stays 0.
- reset pulsed low during element 3 of a vector → all outputs 0 asynchronously. After release, a fresh vector completes with the correct result.
